// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the MDU sequencer.
//   - mdu_state_e : sequencer state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3)
//   - UNIT_MUL / UNIT_DIV : value of the latched unit select bit
//   - XLEN_DEF : default datapath width
package mdu_ctrl_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam logic UNIT_MUL = 1'b0;
  localparam logic UNIT_DIV = 1'b1;

endpackage

// File: rtl/mdu_res_fmt.sv
// Result formatter for the MDU sequencer (purely combinational).
// Picks the requested half of the multiplier or divider response and, for
// word ops, sign-extends bit 31 into the upper half.
// Ports:
//   unit_sel          : 0 = multiplier, 1 = divider
//   res_sel           : mul: 1 = low half / 0 = high half; div: 1 = quotient / 0 = remainder
//   word              : sign-extend the selected value from bit 31
//   mul_hi, mul_lo    : product halves
//   div_q, div_r      : quotient and remainder
//   res_data          : formatted result
module mdu_res_fmt
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            unit_sel,
  input  logic            res_sel,
  input  logic            word,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r,
  output logic [XLEN-1:0] res_data
);

  logic [XLEN-1:0] sel_s;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  // Select the requested response half, then apply word sign-extension.
  always_comb begin
    sel_s    = '0;
    res_data = '0;
    if (unit_sel == UNIT_MUL) begin
      if (res_sel) begin
        sel_s = mul_lo;
      end else begin
        sel_s = mul_hi;
      end
    end else begin
      if (res_sel) begin
        sel_s = div_q;
      end else begin
        sel_s = div_r;
      end
    end
    if (word) begin
      res_data = sext_word(sel_s);
    end else begin
      res_data = sel_s;
    end
  end

endmodule

// File: rtl/exu_mdu_ctrl.sv
// Sequencer for the multi-cycle multiplier and divider behind ID/EX.
// Accepts one mul/div op, holds ID/EX via exu_idle while it is in flight,
// handshakes request/response with the selected unit, formats the result
// and holds it until the EX/MEM side takes it. A flush kills the op.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   flush                    : pipeline flush
//   issue_valid, mul_valid, div_valid, mul_signed, mul_res_lo,
//   div_signed, div_quotient, inst_32, src1, src2 : op from ID/EX
//   md_src1, md_src2, md_signed, md_word          : latched op to the units
//   mul_req_*/mul_resp_*/mul_flush                : multiplier handshake
//   div_req_*/div_resp_*/div_flush                : divider handshake
//   exu_idle                 : ID/EX may advance
//   res_valid, res_ready, res_data                : formatted result
// Optional feature macro MDU_PERF_EN adds perf_mul_cnt, perf_div_cnt and
// perf_busy_cnt (CNT_W bits each, wrapping).
module exu_mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef MDU_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic            mul_valid,
  input  logic            div_valid,
  input  logic [1:0]      mul_signed,
  input  logic            mul_res_lo,
  input  logic [1:0]      div_signed,
  input  logic            div_quotient,
  input  logic            inst_32,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] md_src1,
  output logic [XLEN-1:0] md_src2,
  output logic [1:0]      md_signed,
  output logic            md_word,
  output logic            mul_req_valid,
  input  logic            mul_req_ready,
  output logic            mul_flush,
  input  logic            mul_resp_valid,
  input  logic [XLEN-1:0] mul_resp_hi,
  input  logic [XLEN-1:0] mul_resp_lo,
  output logic            div_req_valid,
  input  logic            div_req_ready,
  output logic            div_flush,
  input  logic            div_resp_valid,
  input  logic [XLEN-1:0] div_resp_q,
  input  logic [XLEN-1:0] div_resp_r,
  output logic            exu_idle,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data
`ifdef MDU_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_mul_cnt,
  output logic [CNT_W-1:0] perf_div_cnt,
  output logic [CNT_W-1:0] perf_busy_cnt
`endif
);

  mdu_state_e      state_r;
  mdu_state_e      state_nxt_s;
  logic            unit_sel_r;
  logic            res_sel_r;
  logic            word_r;
  logic [1:0]      signed_r;
  logic [XLEN-1:0] src1_r;
  logic [XLEN-1:0] src2_r;
  logic [XLEN-1:0] res_data_r;
  logic            res_valid_r;
  logic [XLEN-1:0] fmt_data_s;
  logic            start_s;
  logic            req_ready_s;
  logic            resp_valid_s;
  logic            capture_s;
  logic            done_exit_s;

  // Only the selected unit's handshake inputs matter; the other is ignored.
  assign req_ready_s  = (unit_sel_r == UNIT_MUL) ? mul_req_ready  : div_req_ready;
  assign resp_valid_s = (unit_sel_r == UNIT_MUL) ? mul_resp_valid : div_resp_valid;

  assign start_s     = (state_r == ST_IDLE) & issue_valid & (mul_valid | div_valid) & ~flush;
  // Flush beats a same-cycle response: nothing is captured.
  assign capture_s   = (state_r == ST_WAIT) & resp_valid_s & ~flush;
  assign done_exit_s = (state_r == ST_DONE) & (res_ready | flush);

  assign md_src1   = src1_r;
  assign md_src2   = src2_r;
  assign md_signed = signed_r;
  assign md_word   = word_r;
  assign res_data  = res_data_r;
  assign res_valid = res_valid_r;

  mdu_res_fmt #(
    .XLEN     (XLEN)
  ) u_fmt (
    .unit_sel (unit_sel_r),
    .res_sel  (res_sel_r),
    .word     (word_r),
    .mul_hi   (mul_resp_hi),
    .mul_lo   (mul_resp_lo),
    .div_q    (div_resp_q),
    .div_r    (div_resp_r),
    .res_data (fmt_data_s)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus combinational handshake, flush and idle outputs.
  always_comb begin
    state_nxt_s   = state_r;
    exu_idle      = 1'b0;
    mul_req_valid = 1'b0;
    div_req_valid = 1'b0;
    mul_flush     = 1'b0;
    div_flush     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        exu_idle = ~start_s;
        if (start_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        mul_req_valid = (unit_sel_r == UNIT_MUL);
        div_req_valid = (unit_sel_r == UNIT_DIV);
        mul_flush     = flush & (unit_sel_r == UNIT_MUL);
        div_flush     = flush & (unit_sel_r == UNIT_DIV);
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (req_ready_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        mul_flush = flush & (unit_sel_r == UNIT_MUL);
        div_flush = flush & (unit_sel_r == UNIT_DIV);
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (resp_valid_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        // A flushed result is dropped without letting ID/EX advance.
        exu_idle = res_ready & ~flush;
        if (flush || res_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Latch the accepted op; mul takes priority when both valids are set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_sel_r <= UNIT_MUL;
      res_sel_r  <= 1'b0;
      word_r     <= 1'b0;
      signed_r   <= 2'b00;
      src1_r     <= '0;
      src2_r     <= '0;
    end else if (start_s) begin
      unit_sel_r <= mul_valid ? UNIT_MUL : UNIT_DIV;
      res_sel_r  <= mul_valid ? mul_res_lo : div_quotient;
      signed_r   <= mul_valid ? mul_signed : div_signed;
      word_r     <= inst_32;
      src1_r     <= src1;
      src2_r     <= src2;
    end else begin
      unit_sel_r <= unit_sel_r;
      res_sel_r  <= res_sel_r;
      word_r     <= word_r;
      signed_r   <= signed_r;
      src1_r     <= src1_r;
      src2_r     <= src2_r;
    end
  end

  // Capture the formatted result and hold it until handshake or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_r  <= '0;
      res_valid_r <= 1'b0;
    end else if (capture_s) begin
      res_data_r  <= fmt_data_s;
      res_valid_r <= 1'b1;
    end else if (done_exit_s) begin
      res_data_r  <= res_data_r;
      res_valid_r <= 1'b0;
    end else begin
      res_data_r  <= res_data_r;
      res_valid_r <= res_valid_r;
    end
  end

`ifdef MDU_PERF_EN
  logic [CNT_W-1:0] perf_mul_r;
  logic [CNT_W-1:0] perf_div_r;
  logic [CNT_W-1:0] perf_busy_r;
  logic             done_hs_s;

  // Only a real result handshake counts; a flush in DONE does not.
  assign done_hs_s = (state_r == ST_DONE) & res_ready & ~flush;

  assign perf_mul_cnt  = perf_mul_r;
  assign perf_div_cnt  = perf_div_r;
  assign perf_busy_cnt = perf_busy_r;

  // Wrapping completion and busy-cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_mul_r  <= '0;
      perf_div_r  <= '0;
      perf_busy_r <= '0;
    end else begin
      if (done_hs_s && (unit_sel_r == UNIT_MUL)) begin
        perf_mul_r <= perf_mul_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        perf_mul_r <= perf_mul_r;
      end
      if (done_hs_s && (unit_sel_r == UNIT_DIV)) begin
        perf_div_r <= perf_div_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        perf_div_r <= perf_div_r;
      end
      if (!exu_idle) begin
        perf_busy_r <= perf_busy_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        perf_busy_r <= perf_busy_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exu_mdu_ctrl.sv
// Bench for exu_mdu_ctrl: random ops with a unit responder and a result
// scoreboard, then directed reset / backpressure / flush scenarios.
module tb_exu_mdu_ctrl;

  localparam logic [63:0] K = 64'h5A5A_5A5A_5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, mul_valid, div_valid;
  logic [1:0]  mul_signed, div_signed;
  logic        mul_res_lo, div_quotient, inst_32;
  logic [63:0] src1, src2, md_src1, md_src2;
  logic [1:0]  md_signed;
  logic        md_word, mul_req_valid, mul_flush, div_req_valid, div_flush;
  logic        exu_idle, res_valid;
  logic [63:0] res_data;
  logic        mul_req_ready, div_req_ready, mul_resp_valid, div_resp_valid, res_ready;
  logic [63:0] mul_resp_hi, mul_resp_lo, div_resp_q, div_resp_r;
`ifdef MDU_PERF_EN
  logic [31:0] perf_mul_cnt, perf_div_cnt, perf_busy_cnt;
`endif

  // auto-mode (random phase) and directed-mode copies of unit-side inputs
  bit          auto_en = 1'b0;
  logic        a_mrdy = 0, a_drdy = 0, a_mrv = 0, a_drv = 0, a_rrdy = 0;
  logic [63:0] a_hi = 0, a_lo = 0, a_q = 0, a_r = 0;
  logic        d_mrdy = 0, d_drdy = 0, d_mrv = 0, d_drv = 0, d_rrdy = 0;
  logic [63:0] d_hi = 0, d_lo = 0, d_q = 0, d_r = 0;

  assign mul_req_ready  = auto_en ? a_mrdy : d_mrdy;
  assign div_req_ready  = auto_en ? a_drdy : d_drdy;
  assign mul_resp_valid = auto_en ? a_mrv  : d_mrv;
  assign div_resp_valid = auto_en ? a_drv  : d_drv;
  assign res_ready      = auto_en ? a_rrdy : d_rrdy;
  assign mul_resp_hi    = auto_en ? a_hi : d_hi;
  assign mul_resp_lo    = auto_en ? a_lo : d_lo;
  assign div_resp_q     = auto_en ? a_q  : d_q;
  assign div_resp_r     = auto_en ? a_r  : d_r;

  exu_mdu_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .mul_valid(mul_valid), .div_valid(div_valid), .mul_signed(mul_signed),
    .mul_res_lo(mul_res_lo), .div_signed(div_signed), .div_quotient(div_quotient),
    .inst_32(inst_32), .src1(src1), .src2(src2), .md_src1(md_src1), .md_src2(md_src2),
    .md_signed(md_signed), .md_word(md_word), .mul_req_valid(mul_req_valid),
    .mul_req_ready(mul_req_ready), .mul_flush(mul_flush), .mul_resp_valid(mul_resp_valid),
    .mul_resp_hi(mul_resp_hi), .mul_resp_lo(mul_resp_lo), .div_req_valid(div_req_valid),
    .div_req_ready(div_req_ready), .div_flush(div_flush), .div_resp_valid(div_resp_valid),
    .div_resp_q(div_resp_q), .div_resp_r(div_resp_r), .exu_idle(exu_idle),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef MDU_PERF_EN
    , .perf_mul_cnt(perf_mul_cnt), .perf_div_cnt(perf_div_cnt), .perf_busy_cnt(perf_busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mul;
    bit          rsel;
    bit          word;
    logic [1:0]  sgn;
    logic [63:0] a;
    logic [63:0] b;
  } op_t;

  op_t         op_q[$];
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference formatting straight from the selection and word rules.
  function automatic logic [63:0] ref_fmt(op_t o, logic [63:0] hi, logic [63:0] lo,
                                          logic [63:0] q, logic [63:0] r);
    logic [63:0] s;
    if (o.is_mul) s = o.rsel ? lo : hi;
    else          s = o.rsel ? q : r;
    if (o.word) s = 64'($signed(s[31:0]));
    return s;
  endfunction

  // Unit responder for the random phase.
  initial begin : unit_model
    bit waiting = 0;
    int dly = 0;
    op_t o;
    forever begin
      @(negedge clk);
      if (!auto_en) continue;
      a_mrv = 0; a_drv = 0;
      a_mrdy = 1'($urandom_range(0, 1));
      a_drdy = 1'($urandom_range(0, 1));
      if (mul_req_valid || div_req_valid) begin
        chk("op_pending", 64'(op_q.size() != 0), 64'd1);
        if (op_q.size() != 0) begin
          o = op_q[0];
          chk("req_unit_mul", 64'(mul_req_valid), 64'(o.is_mul));
          chk("md_src1", md_src1, o.a);
          chk("md_src2", md_src2, o.b);
          chk("md_signed", 64'(md_signed), 64'(o.sgn));
          chk("md_word", 64'(md_word), 64'(o.word));
          // junk response while still requesting must be ignored
          if ($urandom_range(0, 3) == 0) begin
            a_hi = {$urandom, $urandom}; a_lo = {$urandom, $urandom};
            a_q = {$urandom, $urandom}; a_r = {$urandom, $urandom};
            if (o.is_mul) a_mrv = 1; else a_drv = 1;
          end
          if ((o.is_mul && a_mrdy) || (!o.is_mul && a_drdy)) begin
            waiting = 1;
            dly = $urandom_range(0, 3);
          end
        end
      end else if (waiting) begin
        a_hi = {$urandom, $urandom}; a_lo = {$urandom, $urandom};
        a_q = {$urandom, $urandom}; a_r = {$urandom, $urandom};
        if (dly == 0) begin
          if (o.is_mul) a_mrv = 1; else a_drv = 1;
          exp_q.push_back(ref_fmt(o, a_hi, a_lo, a_q, a_r));
          void'(op_q.pop_front());
          waiting = 0;
        end else begin
          dly--;
          // response from the other unit must be ignored
          if (o.is_mul) a_drv = 1'($urandom_range(0, 1));
          else          a_mrv = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Result monitor / scoreboard for the random phase.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!auto_en) continue;
      a_rrdy = 0;
      if (res_valid) begin
        chk("res_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("res_data", res_data, exp_q[0]);
          a_rrdy = ($urandom_range(0, 2) != 0);
          #1;
          chk("idle_at_done", 64'(exu_idle), 64'(a_rrdy));
          if (a_rrdy) begin
            void'(exp_q.pop_front());
            n_done++;
          end
        end
      end
    end
  end

  task automatic set_issue(input bit v, input bit mv, input bit dv, input bit rsel,
                           input bit word, input logic [63:0] a, input logic [63:0] b);
    issue_valid = v; mul_valid = mv; div_valid = dv;
    mul_res_lo = rsel; div_quotient = rsel; inst_32 = word; src1 = a; src2 = b;
  endtask

  // One op with single-cycle ready/resp and res_ready in the first DONE cycle.
  task automatic do_op(input bit mv, input bit dv, input bit rsel, input bit word,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] rv,
                       output logic [63:0] got, output logic vld, output logic [3:0] idle_tr);
    @(negedge clk);
    set_issue(1, mv, dv, rsel, word, a, b);
    #1 idle_tr[0] = exu_idle;
    @(negedge clk);
    set_issue(0, 0, 0, 0, 0, 0, 0);
    d_mrdy = 1; d_drdy = 1;
    #1 idle_tr[1] = exu_idle;
    @(negedge clk);
    d_mrdy = 0; d_drdy = 0;
    d_lo = rv; d_hi = ~rv; d_q = rv ^ K; d_r = ~(rv ^ K);
    d_mrv = 1; d_drv = 1;
    #1 idle_tr[2] = exu_idle;
    @(negedge clk);
    d_mrv = 0; d_drv = 0;
    got = res_data; vld = res_valid;
    d_rrdy = 1;
    #1 idle_tr[3] = exu_idle;
    @(negedge clk);
    d_rrdy = 0;
  endtask

  initial begin : main
    logic [63:0] got;
    logic        vld;
    logic [3:0]  itr;
    op_t         o;
    int          sel;
    bit          ok;

    rst = 1; flush = 0;
    mul_signed = 0; div_signed = 0;
    set_issue(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_md_src1", md_src1, 64'd0);
    chk("rst_req", 64'({mul_req_valid, div_req_valid, mul_flush, div_flush}), 64'd0);
    chk("rst_idle", 64'(exu_idle), 64'd1);
    repeat (2) @(negedge clk);
    rst = 0;

    // ---------------- random phase ----------------
    auto_en = 1;
    for (int n = 0; n < 40; n++) begin
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk); #2;
        ok = !res_valid && exu_idle;
      end
      chk("idle_wait_timeout", 64'(ok), 64'd1);
      sel = $urandom_range(1, 3);
      o.is_mul = sel[0];
      o.rsel = 1'($urandom_range(0, 1));
      o.word = 1'($urandom_range(0, 1));
      mul_signed = 2'($urandom_range(0, 3));
      div_signed = 2'($urandom_range(0, 3));
      o.sgn = o.is_mul ? mul_signed : div_signed;
      o.a = {$urandom, $urandom}; o.b = {$urandom, $urandom};
      op_q.push_back(o);
      set_issue(1, sel[0], sel[1], o.rsel, o.word, o.a, o.b);
      #1 chk("idle_drop_on_start", 64'(exu_idle), 64'd0);
      @(negedge clk); #2;
      set_issue(0, 0, 0, 0, 0, 0, 0);
    end
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = (n_done == 40);
    end
    chk("random_done_count", 64'(n_done), 64'd40);
    #2 auto_en = 0;
    mul_signed = 0; div_signed = 0;

    // ---------------- MUL low half ----------------
    do_op(1, 0, 1, 0, 64'd7, 64'd6, 64'd42, got, vld, itr);
    chk("mul_lo_valid", 64'(vld), 64'd1);
    chk("mul_lo_data", got, 64'd42);
    chk("mul_lo_idle_trace", 64'(itr), 64'b1000);

    // ---------------- DIVW remainder ----------------
    do_op(0, 1, 0, 1, 64'd100, 64'd3, ~64'h0000_0000_8000_0001 ^ K, got, vld, itr);
    chk("divw_rem_data", got, 64'hFFFF_FFFF_8000_0001);
    chk("divw_idle_trace", 64'(itr), 64'b1000);

    // ---------------- Backpressure ----------------
    @(negedge clk);
    set_issue(1, 1, 0, 0, 0, 64'h1111, 64'h2222);
    @(negedge clk);
    src1 = 64'h9999; src2 = 64'h8888;   // ID/EX keeps presenting an op
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_held", 64'(mul_req_valid), 64'd1);
      chk("bp_src_stable", {md_src1[31:0], md_src2[31:0]}, {32'h1111, 32'h2222});
      @(negedge clk);
    end
    d_mrdy = 1;
    @(negedge clk);
    d_mrdy = 0; d_hi = 64'hCAFE_0000_0000_BEEF; d_lo = 64'h1; d_mrv = 1;
    @(negedge clk);
    d_mrv = 0; d_hi = 64'h0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_res_valid", 64'(res_valid), 64'd1);
      chk("bp_res_stable", res_data, 64'hCAFE_0000_0000_BEEF);
      chk("bp_no_restart", {63'd0, mul_req_valid} | (md_src1 ^ 64'h1111), 64'd0);
      @(negedge clk);
    end
    set_issue(0, 0, 0, 0, 0, 0, 0);
    d_rrdy = 1;
    #1 chk("bp_idle_handshake", 64'(exu_idle), 64'd1);
    @(negedge clk);
    d_rrdy = 0;
    chk("bp_after", 64'({res_valid, mul_req_valid}), 64'd0);

    // ---------------- Flush in WAIT ----------------
    @(negedge clk);
    set_issue(1, 0, 1, 1, 0, 64'h55, 64'h5);
    @(negedge clk);
    set_issue(0, 0, 0, 0, 0, 0, 0);
    d_drdy = 1;
    @(negedge clk);
    d_drdy = 0; flush = 1;
    #1 chk("fw_flush_outs", 64'({div_flush, mul_flush, exu_idle}), 64'b100);
    @(negedge clk);
    flush = 0; d_drv = 1; d_q = 64'h77;
    #1 chk("fw_idle_next", 64'({exu_idle, div_req_valid, div_flush}), 64'b100);
    @(negedge clk);
    d_drv = 0;
    for (int i = 0; i < 3; i++) begin
      chk("fw_no_result", 64'(res_valid), 64'd0);
      @(negedge clk);
    end

    // ---------------- Flush in DONE, both valids ----------------
    set_issue(1, 1, 1, 1, 0, 64'h3, 64'h4);
    @(negedge clk);
    set_issue(0, 0, 0, 0, 0, 0, 0);
    chk("fd_mul_wins", 64'({mul_req_valid, div_req_valid}), 64'b10);
    d_mrdy = 1;
    @(negedge clk);
    d_mrdy = 0; d_lo = 64'hABC; d_mrv = 1;
    @(negedge clk);
    d_mrv = 0;
    chk("fd_res_valid", 64'(res_valid), 64'd1);
    d_rrdy = 1; flush = 1;
    #1 chk("fd_idle_low", 64'({exu_idle, mul_flush}), 64'd0);
    @(negedge clk);
    d_rrdy = 0; flush = 0;
    chk("fd_discarded", 64'(res_valid), 64'd0);
    do_op(1, 1, 1, 0, 64'h9, 64'h9, 64'h1234, got, vld, itr);
    chk("fd_next_mul_sel", got, 64'h1234);

    // ---------------- Async reset in WAIT ----------------
    @(negedge clk);
    set_issue(1, 1, 0, 1, 1, 64'hA5A5, 64'h5A5A);
    @(negedge clk);
    set_issue(0, 0, 0, 0, 0, 0, 0);
    d_mrdy = 1;
    @(negedge clk);
    d_mrdy = 0;
    #2 rst = 1;
    #1;
    chk("ar_md", md_src1 | md_src2 | 64'(md_word), 64'd0);
    chk("ar_res", res_data | 64'(res_valid), 64'd0);
    chk("ar_outs", 64'({mul_req_valid, div_req_valid, mul_flush, div_flush, exu_idle}), 64'b00001);
`ifdef MDU_PERF_EN
    chk("ar_perf", 64'(perf_mul_cnt | perf_div_cnt | perf_busy_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 0;
    do_op(1, 0, 0, 0, 64'h1, 64'h2, 64'h10, got, vld, itr);
    chk("ar_op1_hi", got, ~64'h10);
    do_op(1, 0, 1, 0, 64'h1, 64'h2, 64'h20, got, vld, itr);
    chk("ar_op2_lo", got, 64'h20);
`ifdef MDU_PERF_EN
    chk("perf_mul_cnt", 64'(perf_mul_cnt), 64'd2);
    chk("perf_div_cnt", 64'(perf_div_cnt), 64'd0);
    chk("perf_busy_cnt", 64'(perf_busy_cnt), 64'd6);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
